// File: rtl/ddr_line_master_pkg.sv
// Shared types and defaults for the DDR line initiators.
package ddr_line_master_pkg;

  typedef logic [31:0] rvga_word;
  typedef logic [7:0]  rvga_byte;

  localparam int LINE_WORDS_DEFAULT = 8;
  localparam int TIMEOUT_DEFAULT    = 1024;

  // Number of byte-offset bits covered by one line.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  localparam int LINE_OFF_W_DEFAULT = line_off_w(LINE_WORDS_DEFAULT);

endpackage

// File: rtl/ddr_watchdog.sv
// Per-word watchdog: counts wait cycles and flags a responder that never answers.
module ddr_watchdog
  import ddr_line_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires in the last allowed wait cycle, so the request is held exactly TIMEOUT cycles.
  assign expired = (TIMEOUT != 0) && inc && (count == LAST);

endmodule

// File: rtl/ddr_line_master.sv
// Converts one cache-line request into LINE_WORDS single-word DDR handshakes.
module ddr_line_master
  import ddr_line_master_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [32*LINE_WORDS-1:0] req_wline,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [32*LINE_WORDS-1:0] rsp_rline,
  output logic [31:0]             ddr_addr,
  output logic                    ddr_read,
  output logic                    ddr_write,
  output logic [31:0]             ddr_wdata,
  input  logic [31:0]             ddr_rdata,
  input  logic                    ddr_resp
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = line_off_w(LINE_WORDS);
  localparam rvga_word OFF_MASK = rvga_word'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  rvga_word                base;
  logic                    wr;
  logic                    err;
  logic [32*LINE_WORDS-1:0] wline;
  logic [32*LINE_WORDS-1:0] rline;

  logic accept, word_resp, wd_clear, wd_inc, expired;

  assign accept    = (state == IDLE) && req_valid;
  assign word_resp = (state == XFER) && ddr_resp;
  assign wd_clear  = accept || word_resp;
  assign wd_inc    = (state == XFER) && !ddr_resp;
  assign rsp_rline = rline;

  ddr_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .inc    (wd_inc),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The ddr request stays up until ddr_resp or the watchdog, never dropped early.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    ddr_read   = 1'b0;
    ddr_write  = 1'b0;
    ddr_addr   = '0;
    ddr_wdata  = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = XFER;
        end
      end
      XFER: begin
        ddr_read  = !wr;
        ddr_write = wr;
        ddr_addr  = base + 32'({idx, 2'b00});
        ddr_wdata = wline[32*idx +: 32];
        if (ddr_resp) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end
        end else if (expired) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid  = 1'b1;
        rsp_err    = err;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      base  <= '0;
      wr    <= 1'b0;
      err   <= 1'b0;
      wline <= '0;
      rline <= '0;
    end else begin
      if (accept) begin
        base  <= req_addr & ~OFF_MASK;
        wr    <= req_write;
        wline <= req_wline;
        idx   <= '0;
        err   <= 1'b0;
      end
      if (word_resp) begin
        if (!wr) begin
          rline[32*idx +: 32] <= ddr_rdata;
        end
        if (idx != LAST_IDX) begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (expired) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_line_master.sv
// Directed bench for ddr_line_master: table-driven line transfers against a byte memory responder.
module tb_ddr_line_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [255:0] req_wline;
  logic         rsp_valid;
  logic         rsp_err;
  logic [255:0] rsp_rline;
  logic [31:0]  ddr_addr;
  logic         ddr_read;
  logic         ddr_write;
  logic [31:0]  ddr_wdata;
  logic [31:0]  ddr_rdata;
  logic         ddr_resp;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  int          lat = 0;
  logic        resp_en = 1'b1;
  int          stab_viol = 0;
  int          drop_viol = 0;
  int          req_cycles = 0;
  logic [31:0] addr_log [$];

  ddr_line_master #(
    .LINE_WORDS(8),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wline(req_wline),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rline(rsp_rline),
    .ddr_addr (ddr_addr),
    .ddr_read (ddr_read),
    .ddr_write(ddr_write),
    .ddr_wdata(ddr_wdata),
    .ddr_rdata(ddr_rdata),
    .ddr_resp (ddr_resp)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global timeout");
  end

  typedef struct {
    string       name;
    logic        write;
    logic [31:0] addr;
    int          lat;
    logic        resp_on;
    logic [31:0] wbase;
    logic [31:0] exp_base;
    logic        exp_err;
    int          exp_cycles;
    logic [31:0] exp_w0;
    logic [31:0] exp_w7;
  } vec_t;

  function automatic vec_t mkVec(input string n, input logic w, input logic [31:0] a,
                                 input int l, input logic on, input logic [31:0] wb,
                                 input logic [31:0] eb, input logic ee, input int ec,
                                 input logic [31:0] e0, input logic [31:0] e7);
    vec_t v;
    v.name = n; v.write = w; v.addr = a; v.lat = l; v.resp_on = on; v.wbase = wb;
    v.exp_base = eb; v.exp_err = ee; v.exp_cycles = ec; v.exp_w0 = e0; v.exp_w7 = e7;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  // Big-endian byte memory responder with programmable wait states.
  initial begin
    logic [31:0] held_addr, held_wdata;
    logic        held_wr;
    logic        pending;
    logic [7:0]  a;
    int          wait_cnt;
    ddr_resp = 1'b0;
    ddr_rdata = '0;
    wait_cnt = 0;
    pending = 1'b0;
    held_addr = '0; held_wdata = '0; held_wr = 1'b0;
    forever begin
      @(negedge clk);
      ddr_resp = 1'b0;
      ddr_rdata = '0;
      if (ddr_read || ddr_write) begin
        if (wait_cnt == 0) begin
          held_addr = ddr_addr; held_wdata = ddr_wdata; held_wr = ddr_write;
        end else if (ddr_addr != held_addr || ddr_wdata != held_wdata || ddr_write != held_wr) begin
          stab_viol++;
        end
        if (!resp_en) begin
          req_cycles++;
          wait_cnt++;
        end else if (wait_cnt >= lat) begin
          a = ddr_addr[7:0];
          if (ddr_write) begin
            mem[a] = ddr_wdata[31:24]; mem[a + 8'd1] = ddr_wdata[23:16];
            mem[a + 8'd2] = ddr_wdata[15:8]; mem[a + 8'd3] = ddr_wdata[7:0];
          end else begin
            ddr_rdata = mem_word(a);
          end
          addr_log.push_back(ddr_addr);
          ddr_resp = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
        pending = !ddr_resp;
      end else begin
        if (pending) drop_viol++;
        pending = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one line request at a negedge and wait (bounded) for the completion pulse.
  task automatic applyStimulus(input vec_t v, output logic got, output logic err, output int cyc);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr = v.addr;
    for (int j = 0; j < 8; j++) req_wline[32*j +: 32] = v.wbase + 32'(j);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    err = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      if (rsp_valid) begin
        got = 1'b1;
        err = rsp_err;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic runVector(input vec_t v);
    logic got, err;
    int   cyc, bad;
    lat = v.lat;
    resp_en = v.resp_on;
    stab_viol = 0; drop_viol = 0; req_cycles = 0;
    addr_log.delete();
    checkOutput({v.name, "_ready"}, req_ready, 1'b1);
    applyStimulus(v, got, err, cyc);
    checkOutput({v.name, "_rsp"}, got, 1'b1);
    checkOutput({v.name, "_err"}, err, v.exp_err);
    checkOutput({v.name, "_cycles"}, cyc, v.exp_cycles);
    if (v.exp_err) begin
      checkOutput({v.name, "_req_held"}, req_cycles, v.exp_cycles);
    end else begin
      if (v.write) begin
        checkOutput({v.name, "_mem_w0"}, mem_word(v.exp_base[7:0]), v.exp_w0);
        checkOutput({v.name, "_mem_w7"}, mem_word(v.exp_base[7:0] + 8'd28), v.exp_w7);
      end else begin
        checkOutput({v.name, "_rline_w0"}, rsp_rline[31:0], v.exp_w0);
        checkOutput({v.name, "_rline_w7"}, rsp_rline[255:224], v.exp_w7);
      end
      checkOutput({v.name, "_addr_count"}, addr_log.size(), 8);
      bad = 0;
      for (int j = 0; j < addr_log.size(); j++)
        if (addr_log[j] != v.exp_base + 32'(4 * j)) bad++;
      checkOutput({v.name, "_addr_seq"}, bad, 0);
      checkOutput({v.name, "_stable"}, stab_viol, 0);
      checkOutput({v.name, "_no_drop"}, drop_viol, 0);
    end
    @(negedge clk);
    checkOutput({v.name, "_pulse"}, rsp_valid, 1'b0);
    checkOutput({v.name, "_req_idle"}, ddr_read | ddr_write, 1'b0);
    resp_en = 1'b1;
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a - 'h40);
    vecs[0] = mkVec("rd_40",     1'b0, 32'h4C, 0, 1'b1, 32'h0,        32'h40, 1'b0,  8, 32'h00010203, 32'h1C1D1E1F);
    vecs[1] = mkVec("wr_80",     1'b1, 32'h80, 0, 1'b1, 32'hA0A0A000, 32'h80, 1'b0,  8, 32'hA0A0A000, 32'hA0A0A007);
    vecs[2] = mkVec("rd_80_l5",  1'b0, 32'h9F, 5, 1'b1, 32'h0,        32'h80, 1'b0, 48, 32'hA0A0A000, 32'hA0A0A007);
    vecs[3] = mkVec("wr_c0_l5",  1'b1, 32'hC4, 5, 1'b1, 32'hC0DE0000, 32'hC0, 1'b0, 48, 32'hC0DE0000, 32'hC0DE0007);
    vecs[4] = mkVec("rd_c0_l2",  1'b0, 32'hDF, 2, 1'b1, 32'h0,        32'hC0, 1'b0, 24, 32'hC0DE0000, 32'hC0DE0007);
    vecs[5] = mkVec("rd_20_l1",  1'b0, 32'h24, 1, 1'b1, 32'h0,        32'h20, 1'b0, 16, 32'hE0E1E2E3, 32'hFCFDFEFF);
    vecs[6] = mkVec("timeout",   1'b0, 32'h40, 0, 1'b0, 32'h0,        32'h40, 1'b1, 16, 32'h0,        32'h0);
    vecs[7] = mkVec("rd_after",  1'b0, 32'h4C, 0, 1'b1, 32'h0,        32'h40, 1'b0,  8, 32'h00010203, 32'h1C1D1E1F);

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wline = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", req_ready, 1'b1);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_ddr_req", ddr_read | ddr_write, 1'b0);
    checkOutput("reset_ddr_addr", ddr_addr, 32'h0);
    checkOutput("reset_rline", rsp_rline, 256'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    $display("[TB] back-to-back requests");
    lat = 0; resp_en = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4C; req_wline = '0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h60;
    checkOutput("b2b_ready_busy", req_ready, 1'b0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    checkOutput("b2b_first_rsp", rsp_valid, 1'b1);
    checkOutput("b2b_ready_in_done", req_ready, 1'b0);
    checkOutput("b2b_first_w7", rsp_rline[255:224], 32'h1C1D1E1F);
    @(negedge clk);
    checkOutput("b2b_ready_after_done", req_ready, 1'b1);
    checkOutput("b2b_single_pulse", rsp_valid, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("b2b_second_start", ddr_read, 1'b1);
    checkOutput("b2b_second_addr", ddr_addr, 32'h60);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    checkOutput("b2b_second_rsp", rsp_valid, 1'b1);
    checkOutput("b2b_second_w0", rsp_rline[31:0], 32'h20212223);
    checkOutput("b2b_second_w7", rsp_rline[255:224], 32'h3C3D3E3F);
    @(negedge clk);

    $display("[TB] reset in the middle of a line");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_addr", ddr_addr, 32'h50);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ddr_read", ddr_read, 1'b0);
    checkOutput("rst_mid_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_mid_ready", req_ready, 1'b1);
    checkOutput("rst_mid_rline", rsp_rline, 256'h0);
    rst_n = 1'b1;
    @(negedge clk);
    runVector(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
